cv32e40x_div_mb: RTL and testbench
==================================

Name: cv32e40x_div_mb

Overview:
Parametrised multi-bit serial integer divider for the EX stage, handling DIV/DIVU/REM/REMU.
- Datapath width (32 or 64) and radix are set by parameters.
- Retires BITS_PER_CYCLE quotient bits per cycle using restoring steps on operand magnitudes.
- Has its own leading-zero counter, so it does not share ALU CLZ or shifter resources.
- Early termination skips leading zero dividend bits; a data-independent-timing mode forces a fixed latency.

Parameters:
WIDTH, 32, operand/result width; legal values 32 or 64.
BITS_PER_CYCLE, 1, quotient bits retired per DIVIDE cycle; legal values 1, 2, 4; must divide WIDTH.

Ports:
clk  in  1  clock.
rst_n  in  1  reset.
operator_i  in  div_opcode_e  DIV_DIV/DIV_DIVU/DIV_REM/DIV_REMU.
data_ind_timing_i  in  1  1 = fixed latency, early termination disabled.
op_a_i  in  WIDTH  dividend.
op_b_i  in  WIDTH  divisor.
valid_i  in  1  operation request; low = kill.
ready_o  out  1  operation retired or killed.
valid_o  out  1  result valid.
ready_i  in  1  downstream accepts result.
result_o  out  WIDTH  quotient or remainder.
Reset: rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset: state IDLE; all registers 0; valid_o=0; result_o=0; ready_o = !valid_i.
- Operands and operator are sampled only in the acceptance cycle (IDLE && valid_i). Later input changes are ignored; valid_i must stay high until retirement.
- Signed ops: magnitudes |a| and |b| are taken. |MIN| is the unsigned value 2^(WIDTH-1).
- Sign flags registered at acceptance:
  - quot_neg = signed && (a_sign ^ b_sign) && b!=0.
  - rem_neg = signed && a_sign.
- Skip amount: skip = data_ind_timing_i ? 0 : floor(clz(|a|)/BITS_PER_CYCLE)*BITS_PER_CYCLE.
- Iteration count: N = (WIDTH-skip)/BITS_PER_CYCLE. If |a|=0 and early termination is on, N=0.
- Registers loaded at acceptance:
  - dividend/quotient shift register = |a| << skip.
  - partial remainder (WIDTH+1 bits) = 0.
  - counter = N.
- One DIVIDE cycle performs BITS_PER_CYCLE combinational restoring steps, MSB first. Each step:
  - rem = {rem, dividend msb}.
  - if rem >= |b|: rem -= |b| and qbit=1; otherwise qbit=0.
  - qbit shifts into the LSB of the dividend register.
- FSM:
  - IDLE: valid_i → DIVIDE, or → FINISH if N=0.
  - DIVIDE: counter decrements each cycle; leaves to FINISH on the cycle the counter reaches 1.
  - FINISH: valid_o=1; on ready_i, ready_o=1 and next state is IDLE.
- Latency: acceptance is cycle 0; valid_o first asserts in cycle N+1.
  - data_ind_timing_i=1 gives exactly WIDTH/BITS_PER_CYCLE+1 cycles, independent of operands and operator.
- Result, combinational from registers:
  - Remainder ops: rem_neg ? -rem : rem.
  - Quotient ops: b==0 → all ones; otherwise quot_neg ? -q : q.
  - The b==0 override is required because early termination leaves the skipped upper quotient bits at 0.
- Division by zero: quotient = all ones; remainder = a (sign preserved).
- Signed overflow MIN/-1: quotient = MIN, remainder = 0. This falls out of the magnitude path and needs no special case.
- Kill: valid_i=0 in any state (including FINISH) → ready_o=1 and valid_o=0 in that cycle; next state is IDLE. No other register needs to be cleared.
- Back-pressure: in FINISH with ready_i=0, valid_o and result_o hold stable indefinitely.
- A new operation may be accepted in the cycle immediately after FINISH retires (back-to-back).

Decomposition:
- cv32e40x_pkg:
  - reuse div_opcode_e.
  - add div_mb_state_e {DIV_MB_IDLE, DIV_MB_DIVIDE, DIV_MB_FINISH}.
- Parameter legality checked by elaboration-time assertions in the module.
- Sub-module cv32e40x_div_clz:
  - parametrised WIDTH leading-zero counter, purely combinational.
  - output $clog2(WIDTH)+1 bits; returns WIDTH for an all-zero input.

Test Plan (WIDTH=32 unless stated):
- DIVU 100/7, BITS_PER_CYCLE=1, data_ind_timing_i=0: clz(100)=25, so N=7. valid_o in cycle 8, result 14. REMU with the same operands → 2.
- DIV -7/2 → 0xFFFFFFFD (-3). REM -7/2 → 0xFFFFFFFF (-1). REM 7/-2 → 1.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- Division by zero:
  - DIVU 5/0 → 0xFFFFFFFF.
  - DIV -5/0 → 0xFFFFFFFF.
  - REM -5/0 → 0xFFFFFFFB.
  - DIVU 0/0 → 0xFFFFFFFF with valid_o in cycle 1.
- data_ind_timing_i=1, BITS_PER_CYCLE=2:
  - DIVU 1/1 and 0xFFFFFFFF/3 both produce valid_o in exactly cycle 17, with results 1 and 0x55555555.
  - Repeat with WIDTH=64, BITS_PER_CYCLE=4 → cycle 17.
- Kill and back-pressure:
  - Drop valid_i in DIVIDE cycle 3 → ready_o=1 in the same cycle, IDLE next cycle.
  - Then DIVU 9/3 → 3.
  - Hold ready_i=0 for 5 cycles in FINISH → valid_o=1 and result_o stable throughout. Retirement then occurs on the ready_i cycle.

Source files
------------

// File: rtl/cv32e40x_pkg.sv
// rtl/cv32e40x_pkg.sv - shared divider opcode/state types and opcode decode helpers
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        DIV_DIV  = 2'b00,
        DIV_DIVU = 2'b01,
        DIV_REM  = 2'b10,
        DIV_REMU = 2'b11
    } div_opcode_e;

    typedef enum logic [1:0] {
        DIV_MB_IDLE   = 2'b00,
        DIV_MB_DIVIDE = 2'b01,
        DIV_MB_FINISH = 2'b10
    } div_mb_state_e;

    function automatic logic div_is_signed(input div_opcode_e op);
        return (op == DIV_DIV) || (op == DIV_REM);
    endfunction

    function automatic logic div_is_rem(input div_opcode_e op);
        return (op == DIV_REM) || (op == DIV_REMU);
    endfunction

endpackage

// File: rtl/cv32e40x_div_clz.sv
// rtl/cv32e40x_div_clz.sv - combinational leading-zero counter, returns WIDTH for zero input
module cv32e40x_div_clz #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         data_i,
    output logic [$clog2(WIDTH):0]   clz_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    // Scanning LSB to MSB lets the highest set bit win.
    always_comb begin
        clz_o = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                clz_o = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/cv32e40x_div_mb.sv
// rtl/cv32e40x_div_mb.sv - multi-bit restoring serial divider for DIV/DIVU/REM/REMU
module cv32e40x_div_mb
    import cv32e40x_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  div_opcode_e       operator_i,
    input  logic              data_ind_timing_i,
    input  logic [WIDTH-1:0]  op_a_i,
    input  logic [WIDTH-1:0]  op_b_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [WIDTH-1:0]  result_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    if (!(WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
        $error("cv32e40x_div_mb: WIDTH must be 32 or 64");
    end
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4)) begin : g_bad_bpc
        $error("cv32e40x_div_mb: BITS_PER_CYCLE must be 1, 2 or 4");
    end
    if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_ratio
        $error("cv32e40x_div_mb: BITS_PER_CYCLE must divide WIDTH");
    end

    div_mb_state_e     state_q, state_d;
    logic [WIDTH-1:0]  dividend_q, dividend_d;
    logic [WIDTH-1:0]  abs_b_q, abs_b_d;
    logic [WIDTH:0]    rem_q, rem_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              quot_neg_q, quot_neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic              op_rem_q, op_rem_d;
    logic              b_zero_q, b_zero_d;

    logic              op_signed, a_neg, b_neg, accept;
    logic [WIDTH-1:0]  abs_a, abs_b;
    logic [CW-1:0]     clz_a, skip, iter;
    logic [WIDTH-1:0]  step_div;
    logic [WIDTH:0]    step_rem;
    logic [WIDTH-1:0]  quot, rem_mag;

    assign op_signed = div_is_signed(operator_i);
    assign a_neg     = op_signed & op_a_i[WIDTH-1];
    assign b_neg     = op_signed & op_b_i[WIDTH-1];
    assign abs_a     = a_neg ? -op_a_i : op_a_i;
    assign abs_b     = b_neg ? -op_b_i : op_b_i;
    assign accept    = (state_q == DIV_MB_IDLE) && valid_i;

    cv32e40x_div_clz #(.WIDTH(WIDTH)) u_clz (
        .data_i (abs_a),
        .clz_o  (clz_a)
    );

    // A zero dividend gives clz=WIDTH, so iter collapses to 0 without a special case.
    assign skip = data_ind_timing_i ? '0
                : (clz_a / CW'(BITS_PER_CYCLE)) * CW'(BITS_PER_CYCLE);
    assign iter = (CW'(WIDTH) - skip) / CW'(BITS_PER_CYCLE);

    always_comb begin
        step_div = dividend_q;
        step_rem = rem_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            step_rem = {step_rem[WIDTH-1:0], step_div[WIDTH-1]};
            step_div = {step_div[WIDTH-2:0], 1'b0};
            if (step_rem >= {1'b0, abs_b_q}) begin
                step_rem    = step_rem - {1'b0, abs_b_q};
                step_div[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_MB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_MB_IDLE: begin
                if (valid_i) begin
                    state_d = (iter == '0) ? DIV_MB_FINISH : DIV_MB_DIVIDE;
                end
            end
            DIV_MB_DIVIDE: begin
                if (!valid_i) begin
                    state_d = DIV_MB_IDLE;
                end else if (cnt_q == CW'(1)) begin
                    state_d = DIV_MB_FINISH;
                end
            end
            DIV_MB_FINISH: begin
                if (!valid_i || ready_i) begin
                    state_d = DIV_MB_IDLE;
                end
            end
            default: state_d = DIV_MB_IDLE;
        endcase
    end

    always_comb begin
        valid_o = 1'b0;
        ready_o = !valid_i;
        if (state_q == DIV_MB_FINISH) begin
            valid_o = valid_i;
            ready_o = !valid_i || ready_i;
        end
    end

    always_comb begin
        dividend_d = dividend_q;
        abs_b_d    = abs_b_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        op_rem_d   = op_rem_q;
        b_zero_d   = b_zero_q;
        if (accept) begin
            dividend_d = abs_a << skip;
            abs_b_d    = abs_b;
            rem_d      = '0;
            cnt_d      = iter;
            b_zero_d   = (op_b_i == '0);
            quot_neg_d = op_signed & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]) & (op_b_i != '0);
            rem_neg_d  = a_neg;
            op_rem_d   = div_is_rem(operator_i);
        end else if (state_q == DIV_MB_DIVIDE) begin
            dividend_d = step_div;
            rem_d      = step_rem;
            cnt_d      = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend_q <= '0;
            abs_b_q    <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            op_rem_q   <= 1'b0;
            b_zero_q   <= 1'b0;
        end else begin
            dividend_q <= dividend_d;
            abs_b_q    <= abs_b_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            op_rem_q   <= op_rem_d;
            b_zero_q   <= b_zero_d;
        end
    end

    // Skipped upper quotient bits stay 0, so divide-by-zero must be forced to all ones.
    assign quot     = quot_neg_q ? -dividend_q : dividend_q;
    assign rem_mag  = rem_q[WIDTH-1:0];
    assign result_o = op_rem_q ? (rem_neg_q ? -rem_mag : rem_mag)
                               : (b_zero_q ? '1 : quot);

endmodule

// File: tb/tb_cv32e40x_div_mb.sv
// tb/tb_cv32e40x_div_mb.sv - self-checking bench for cv32e40x_div_mb at three width/radix points
module tb_cv32e40x_div_mb;
    import cv32e40x_pkg::*;

    logic        clk;
    logic        rst_n;
    div_opcode_e operator;
    logic        dit;
    logic [63:0] op_a, op_b;
    logic        valid0, valid1, valid2;
    logic        ready_i;
    logic        ready_o0, ready_o1, ready_o2;
    logic        valid_o0, valid_o1, valid_o2;
    logic [31:0] res0, res1;
    logic [63:0] res2;

    int checks = 0;
    int errors = 0;

    cv32e40x_div_mb #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut_w32_b1 (
        .clk(clk), .rst_n(rst_n), .operator_i(operator), .data_ind_timing_i(dit),
        .op_a_i(op_a[31:0]), .op_b_i(op_b[31:0]), .valid_i(valid0), .ready_o(ready_o0),
        .valid_o(valid_o0), .ready_i(ready_i), .result_o(res0)
    );

    cv32e40x_div_mb #(.WIDTH(32), .BITS_PER_CYCLE(2)) u_dut_w32_b2 (
        .clk(clk), .rst_n(rst_n), .operator_i(operator), .data_ind_timing_i(dit),
        .op_a_i(op_a[31:0]), .op_b_i(op_b[31:0]), .valid_i(valid1), .ready_o(ready_o1),
        .valid_o(valid_o1), .ready_i(ready_i), .result_o(res1)
    );

    cv32e40x_div_mb #(.WIDTH(64), .BITS_PER_CYCLE(4)) u_dut_w64_b4 (
        .clk(clk), .rst_n(rst_n), .operator_i(operator), .data_ind_timing_i(dit),
        .op_a_i(op_a), .op_b_i(op_b), .valid_i(valid2), .ready_o(ready_o2),
        .valid_o(valid_o2), .ready_i(ready_i), .result_o(res2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wid(input int s);
        return (s == 2) ? 64 : 32;
    endfunction

    function automatic int bpc(input int s);
        return (s == 0) ? 1 : ((s == 1) ? 2 : 4);
    endfunction

    function automatic logic vo(input int s);
        return (s == 0) ? valid_o0 : ((s == 1) ? valid_o1 : valid_o2);
    endfunction

    function automatic logic ro(input int s);
        return (s == 0) ? ready_o0 : ((s == 1) ? ready_o1 : ready_o2);
    endfunction

    function automatic logic [63:0] rsl(input int s);
        return (s == 0) ? {32'h0, res0} : ((s == 1) ? {32'h0, res1} : res2);
    endfunction

    task automatic set_valid(input int s, input logic v);
        valid0 = (s == 0) & v;
        valid1 = (s == 1) & v;
        valid2 = (s == 2) & v;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division semantics plus RISC-V corner rules.
    function automatic void model(input int s, input div_opcode_e op, input logic [63:0] a_in,
                                  input logic [63:0] b_in, input bit d,
                                  output logic [63:0] res, output int lat);
        int          w    = wid(s);
        int          bp   = bpc(s);
        logic [63:0] mask = (w == 64) ? '1 : 64'hFFFF_FFFF;
        logic [63:0] a    = a_in & mask;
        logic [63:0] b    = b_in & mask;
        logic [63:0] minv = 64'h1 << (w - 1);
        logic [63:0] mag;
        longint      sa, sb;
        bit          sgn;
        int          sig;
        sa  = (w == 64) ? $signed(a) : longint'($signed(a[31:0]));
        sb  = (w == 64) ? $signed(b) : longint'($signed(b[31:0]));
        sgn = (op == DIV_DIV) || (op == DIV_REM);
        case (op)
            DIV_DIVU: res = (b == 0) ? mask : a / b;
            DIV_REMU: res = (b == 0) ? a : a % b;
            DIV_DIV: begin
                if (b == 0) res = mask;
                else if (a == minv && b == mask) res = minv;
                else res = 64'(sa / sb) & mask;
            end
            default: begin
                if (b == 0) res = a;
                else if (a == minv && b == mask) res = 64'h0;
                else res = 64'(sa % sb) & mask;
            end
        endcase
        mag = (sgn && sa < 0) ? (64'(-sa) & mask) : a;
        sig = 0;
        while (mag != 0) begin
            sig++;
            mag = mag >> 1;
        end
        lat = d ? (w / bp + 1) : ((sig + bp - 1) / bp + 1);
    endfunction

    // Entered and left at posedge+1; inputs are scrambled after acceptance.
    task automatic run_op(input int s, input div_opcode_e op, input logic [63:0] a,
                          input logic [63:0] b, input bit d, input int hold,
                          output logic [63:0] res, output int lat);
        logic [63:0] exp_res;
        int          exp_lat;
        int          cyc;
        bit          got;
        string       tag;
        model(s, op, a, b, d, exp_res, exp_lat);
        tag      = $sformatf("inst%0d op%0d a=%h b=%h dit=%0d", s, op, a, b, d);
        operator = op;
        op_a     = a;
        op_b     = b;
        dit      = d;
        ready_i  = (hold == 0);
        set_valid(s, 1'b1);
        cyc = 0;
        got = 0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            if (vo(s)) begin
                got = 1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
                if (cyc == 1) begin
                    op_a     = {$urandom, $urandom};
                    op_b     = {$urandom, $urandom};
                    operator = div_opcode_e'($urandom_range(0, 3));
                    dit      = 1'($urandom_range(0, 1));
                end
            end
        end
        res = rsl(s);
        lat = cyc;
        check({tag, " completed"}, 64'(got), 64'h1);
        check({tag, " result"}, res, exp_res);
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " ready_o at finish"}, 64'(ro(s)), 64'(hold == 0));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check({tag, " held valid_o"}, 64'(vo(s)), 64'h1);
            check({tag, " held result"}, rsl(s), exp_res);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1;
            ready_i = 1'b1;
            @(negedge clk);
            check({tag, " retire ready_o"}, 64'(ro(s)), 64'h1);
            check({tag, " retire valid_o"}, 64'(vo(s)), 64'h1);
        end
        @(posedge clk);
        #1;
        set_valid(s, 1'b0);
        ready_i = 1'b1;
    endtask

    task automatic directed(input string tag, input int s, input div_opcode_e op,
                            input logic [63:0] a, input logic [63:0] b, input bit d,
                            input logic [63:0] exp_res, input int exp_lat);
        logic [63:0] r;
        int          l;
        run_op(s, op, a, b, d, 0, r, l);
        check({tag, " result"}, r, exp_res);
        check({tag, " latency"}, 64'(l), 64'(exp_lat));
    endtask

    initial begin
        logic [63:0] r, a, b;
        int          l;
        rst_n    = 1'b0;
        operator = DIV_DIV;
        dit      = 1'b0;
        op_a     = '0;
        op_b     = '0;
        ready_i  = 1'b1;
        set_valid(0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset valid_o", 64'(valid_o0), 64'h0);
        check("reset result_o", rsl(0), 64'h0);
        check("reset ready_o", 64'(ready_o0), 64'h1);
        check("reset result_o w64", rsl(2), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        directed("divu 100/7", 0, DIV_DIVU, 100, 7, 0, 64'd14, 8);
        directed("remu 100/7", 0, DIV_REMU, 100, 7, 0, 64'd2, 8);
        directed("div -7/2", 0, DIV_DIV, 64'hFFFF_FFF9, 2, 0, 64'hFFFF_FFFD, 4);
        directed("rem -7/2", 0, DIV_REM, 64'hFFFF_FFF9, 2, 0, 64'hFFFF_FFFF, 4);
        directed("rem 7/-2", 0, DIV_REM, 7, 64'hFFFF_FFFE, 0, 64'd1, 4);
        directed("div min/-1", 0, DIV_DIV, 64'h8000_0000, 64'hFFFF_FFFF, 0, 64'h8000_0000, 33);
        directed("rem min/-1", 0, DIV_REM, 64'h8000_0000, 64'hFFFF_FFFF, 0, 64'h0, 33);
        directed("divu 5/0", 0, DIV_DIVU, 5, 0, 0, 64'hFFFF_FFFF, 4);
        directed("div -5/0", 0, DIV_DIV, 64'hFFFF_FFFB, 0, 0, 64'hFFFF_FFFF, 4);
        directed("rem -5/0", 0, DIV_REM, 64'hFFFF_FFFB, 0, 0, 64'hFFFF_FFFB, 4);
        directed("divu 0/0", 0, DIV_DIVU, 0, 0, 0, 64'hFFFF_FFFF, 1);
        directed("dit b2 1/1", 1, DIV_DIVU, 1, 1, 1, 64'h1, 17);
        directed("dit b2 ffffffff/3", 1, DIV_DIVU, 64'hFFFF_FFFF, 3, 1, 64'h5555_5555, 17);
        directed("dit w64 1/1", 2, DIV_DIVU, 1, 1, 1, 64'h1, 17);
        directed("dit w64 ffffffff/3", 2, DIV_DIVU, 64'hFFFF_FFFF, 3, 1, 64'h5555_5555, 17);

        operator = DIV_DIVU;
        op_a     = 64'hFFFF_0000;
        op_b     = 3;
        dit      = 1'b0;
        ready_i  = 1'b1;
        set_valid(0, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        set_valid(0, 1'b0);
        @(negedge clk);
        check("kill ready_o", 64'(ready_o0), 64'h1);
        check("kill valid_o", 64'(valid_o0), 64'h0);
        @(posedge clk);
        #1;
        directed("divu 9/3 after kill", 0, DIV_DIVU, 9, 3, 0, 64'd3, 5);

        run_op(0, DIV_DIVU, 100, 7, 0, 5, r, l);
        check("backpressure result", r, 64'd14);

        for (int n = 0; n < 90; n++) begin
            a = {$urandom, $urandom} >> $urandom_range(0, 63);
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 9) == 0) b = '0;
            if ($urandom_range(0, 9) == 0) b = '1;
            if ($urandom_range(0, 9) == 0) a = '1 << $urandom_range(0, 63);
            run_op(n % 3, div_opcode_e'($urandom_range(0, 3)), a, b,
                   1'($urandom_range(0, 1)), 0, r, l);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
